// File: rtl/ram_pkg.sv
// ram_pkg: shared state type, range helper and read latency for ram_dp_clr
// RAM_DP_OUTREG_EN (optional macro) adds a second output register stage, RD_LAT becomes 2.
package ram_pkg;
   typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
`ifdef RAM_DP_OUTREG_EN
   localparam int RD_LAT = 2;
`else
   localparam int RD_LAT = 1;
`endif
   function automatic logic in_range(input logic [31:0] addr, input logic [31:0] depth);
      return addr < depth;
   endfunction
endpackage

// File: rtl/ram_clr_seq.sv
// ram_clr_seq: clear sequencer, sweeps every word once after reset or on clr_req
// Ports: clock, reset_n (async, active-low), clr_req in; busy, clr_we, clr_addr out.
module ram_clr_seq import ram_pkg::*; #(
   parameter int ADDR_W = 11,
   parameter int DEPTH = 2**ADDR_W,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              clr_req,
   output logic              busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);
   localparam int CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);
   state_t state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
         cnt <= '0;
      end else begin
         state <= state_nx;
         cnt <= cnt_nx;
      end
   end
   // clr_req is only looked at in IDLE, so a request during a sweep cannot restart it
   always_comb begin
      state_nx = (state == ST_CLEAR) ? ((cnt == LAST) ? ST_IDLE : ST_CLEAR) : (clr_req ? ST_CLEAR : ST_IDLE);
      cnt_nx = (state == ST_CLEAR) ? cnt + CNT_W'(1) : '0;
   end
   assign busy = (state == ST_CLEAR);
   assign clr_we = busy;
   assign clr_addr = cnt[ADDR_W-1:0];
endmodule

// File: rtl/ram_dp_clr.sv
// ram_dp_clr: dual-port RAM (A read/write, B read-only) with hardware clear engine
// Ports: clock, reset_n (async, active-low); a_clken/a_address/a_data/a_wren -> a_q;
//        b_clken/b_address -> b_q; clr_req in, busy out.
// RAM_DP_OUTREG_EN (optional macro): extra output register on a_q and b_q.
module ram_dp_clr import ram_pkg::*; #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 8,
   parameter int DEPTH = 2**ADDR_W,
   parameter int WRITE_FIRST = 1,
   parameter logic [DATA_W-1:0] CLR_VALUE = '0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              a_clken,
   input  logic [ADDR_W-1:0] a_address,
   input  logic [DATA_W-1:0] a_data,
   input  logic              a_wren,
   output logic [DATA_W-1:0] a_q,
   input  logic              b_clken,
   input  logic [ADDR_W-1:0] b_address,
   output logic [DATA_W-1:0] b_q,
   input  logic              clr_req,
   output logic              busy
);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] a_q1, b_q1;
   logic clr_we, a_ok, b_ok;
   logic [ADDR_W-1:0] clr_addr;
   ram_clr_seq #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CLEAR_ON_RESET(CLEAR_ON_RESET)) u_seq (
      .clock(clock),
      .reset_n(reset_n),
      .clr_req(clr_req),
      .busy(busy),
      .clr_we(clr_we),
      .clr_addr(clr_addr)
   );
   assign a_ok = in_range(32'(a_address), 32'(DEPTH));
   assign b_ok = in_range(32'(b_address), 32'(DEPTH));
   // the sweep owns the write port; CPU writes are dropped while it runs
   always_ff @(posedge clock) begin
      if (clr_we)
         mem[clr_addr] <= CLR_VALUE;
      else if (a_clken && a_wren && a_ok)
         mem[a_address] <= a_data;
   end
   // nonblocking array update makes port B (and port A with WRITE_FIRST=0) read-first
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         a_q1 <= '0;
         b_q1 <= '0;
      end else begin
         if (a_clken)
            a_q1 <= (busy || !a_ok) ? '0 : (a_wren && WRITE_FIRST != 0) ? a_data : mem[a_address];
         if (b_clken)
            b_q1 <= (busy || !b_ok) ? '0 : mem[b_address];
      end
   end
`ifdef RAM_DP_OUTREG_EN
   logic [DATA_W-1:0] a_q2, b_q2;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         a_q2 <= '0;
         b_q2 <= '0;
      end else begin
         if (a_clken)
            a_q2 <= busy ? '0 : a_q1;
         if (b_clken)
            b_q2 <= busy ? '0 : b_q1;
      end
   end
   assign a_q = a_q2;
   assign b_q = b_q2;
`else
   assign a_q = a_q1;
   assign b_q = b_q1;
`endif
endmodule

// File: tb/tb_ram_dp_clr.sv
// tb_ram_dp_clr: randomized and directed checks of ram_dp_clr against a word-level array model
module tb_ram_dp_clr;
   import ram_pkg::*;
   localparam int AW = 12;
   localparam int DEPTH = 3072;
   localparam int AW1 = 4;
   localparam int DEPTH1 = 12;
   logic clock = 1'b0;
   logic reset_n = 1'b1;
   always #5 clock = ~clock;
   logic a_clken = 1'b0, a_wren = 1'b0, b_clken = 1'b0, clr_req = 1'b0;
   logic [AW-1:0] a_address = '0, b_address = '0;
   logic [7:0] a_data = '0;
   logic [7:0] a_q, b_q;
   logic busy;
   logic a1_clken = 1'b0, a1_wren = 1'b0, b1_clken = 1'b0, clr1_req = 1'b0;
   logic [AW1-1:0] a1_address = '0, b1_address = '0;
   logic [7:0] a1_data = '0;
   logic [7:0] a1_q, b1_q;
   logic busy1;
   ram_dp_clr #(.ADDR_W(AW), .DATA_W(8), .DEPTH(DEPTH), .WRITE_FIRST(1), .CLR_VALUE(8'h00), .CLEAR_ON_RESET(1)) dut (
      .clock(clock), .reset_n(reset_n),
      .a_clken(a_clken), .a_address(a_address), .a_data(a_data), .a_wren(a_wren), .a_q(a_q),
      .b_clken(b_clken), .b_address(b_address), .b_q(b_q),
      .clr_req(clr_req), .busy(busy)
   );
   ram_dp_clr #(.ADDR_W(AW1), .DATA_W(8), .DEPTH(DEPTH1), .WRITE_FIRST(0), .CLR_VALUE(8'h3C), .CLEAR_ON_RESET(0)) dut_rf (
      .clock(clock), .reset_n(reset_n),
      .a_clken(a1_clken), .a_address(a1_address), .a_data(a1_data), .a_wren(a1_wren), .a_q(a1_q),
      .b_clken(b1_clken), .b_address(b1_address), .b_q(b1_q),
      .clr_req(clr1_req), .busy(busy1)
   );
   int checks = 0, errors = 0;
   logic [7:0] mem_m [DEPTH];
   int clr_cnt;
   bit clr_on;
   logic [7:0] pa [2];
   logic [7:0] pb [2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      logic a_ok, b_ok;
      logic [7:0] av, bv;
      a_ok = int'(a_address) < DEPTH;
      b_ok = int'(b_address) < DEPTH;
      av = (clr_on || !a_ok) ? 8'h00 : a_wren ? a_data : mem_m[a_address];
      bv = (clr_on || !b_ok) ? 8'h00 : mem_m[b_address];
      if (a_clken) begin
         pa[1] = clr_on ? 8'h00 : pa[0];
         pa[0] = av;
      end
      if (b_clken) begin
         pb[1] = clr_on ? 8'h00 : pb[0];
         pb[0] = bv;
      end
      if (clr_on) begin
         mem_m[clr_cnt] = 8'h00;
         clr_cnt++;
         clr_on = clr_cnt < DEPTH;
      end else begin
         if (a_clken && a_wren && a_ok) mem_m[a_address] = a_data;
         if (clr_req) begin
            clr_on = 1'b1;
            clr_cnt = 0;
         end
      end
      @(posedge clock);
      #1;
      chk("busy", 32'(busy), 32'(clr_on));
      chk("a_q", 32'(a_q), 32'(pa[RD_LAT-1]));
      chk("b_q", 32'(b_q), 32'(pb[RD_LAT-1]));
   endtask

   task automatic edge1();
      @(posedge clock);
      #1;
   endtask

   task automatic set_a(input logic c, input logic w, input logic [AW-1:0] ad, input logic [7:0] d);
      a_clken = c;
      a_wren = w;
      a_address = ad;
      a_data = d;
   endtask

   task automatic set_b(input logic c, input logic [AW-1:0] ad);
      b_clken = c;
      b_address = ad;
   endtask

   function automatic logic [AW-1:0] pick_addr();
      int r = int'($urandom % 8);
      return r < 6 ? AW'($urandom_range(0, 31)) : r == 6 ? AW'($urandom_range(3068, 3075)) : AW'(4095);
   endfunction

   task automatic rnd_in(input bit allow_clr);
      a_clken = ($urandom % 4) != 0;
      a_wren = ($urandom % 2) != 0;
      a_address = pick_addr();
      a_data = 8'($urandom);
      b_clken = ($urandom % 4) != 0;
      b_address = ($urandom % 4) == 0 ? a_address : pick_addr();
      clr_req = allow_clr && (($urandom % 16) == 0);
   endtask

   task automatic do_reset(input int cyc);
      reset_n = 1'b0;
      #1;
      pa[0] = 8'h00; pa[1] = 8'h00; pb[0] = 8'h00; pb[1] = 8'h00;
      clr_on = 1'b1;
      clr_cnt = 0;
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_a_q", 32'(a_q), 32'd0);
      chk("rst_b_q", 32'(b_q), 32'd0);
      chk("rst_busy1", 32'(busy1), 32'd0);
      chk("rst_a1_q", 32'(a1_q), 32'd0);
      chk("rst_b1_q", 32'(b1_q), 32'd0);
      repeat (cyc) @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic sweep(input bit rnd, input string tag);
      int n = 0;
      while (busy && n < DEPTH + 16) begin
         if (rnd) rnd_in(1'b1);
         tick();
         n++;
      end
      clr_req = 1'b0;
      chk(tag, 32'(n), 32'(DEPTH));
   endtask

   task automatic rd_b(input logic [AW-1:0] ad, input logic [7:0] exp, input string tag);
      set_b(1'b1, ad);
      repeat (RD_LAT) tick();
      chk(tag, 32'(b_q), 32'(exp));
   endtask

   initial begin
      int n;
      #1;
      do_reset(3);
      sweep(1'b0, "por_sweep_len");
      rd_b(AW'(0), 8'h00, "por_b_0");
      rd_b(AW'(1535), 8'h00, "por_b_1535");
      rd_b(AW'(3071), 8'h00, "por_b_3071");
      set_b(1'b0, '0);
      // write-first
      set_a(1'b1, 1'b1, AW'('h123), 8'hA5);
      tick();
      set_a(1'b1, 1'b0, AW'('h123), 8'h00);
      repeat (RD_LAT - 1) tick();
      chk("wf_a_q", 32'(a_q), 32'hA5);
      rd_b(AW'('h123), 8'hA5, "b_rd_123");
      // collision: B returns the old word
      set_b(1'b0, '0);
      set_a(1'b1, 1'b1, AW'('h040), 8'h11);
      tick();
      set_a(1'b1, 1'b1, AW'('h040), 8'h77);
      set_b(1'b1, AW'('h040));
      tick();
      set_a(1'b0, 1'b0, '0, 8'h00);
      repeat (RD_LAT - 1) tick();
      chk("coll_old", 32'(b_q), 32'h11);
      tick();
      chk("coll_new", 32'(b_q), 32'h77);
      set_b(1'b0, '0);
      // clock enable low blocks write and holds a_q
      set_a(1'b1, 1'b0, AW'('h123), 8'h00);
      repeat (RD_LAT) tick();
      chk("pre_hold_a_q", 32'(a_q), 32'hA5);
      set_a(1'b0, 1'b1, AW'('h123), 8'hFF);
      repeat (3) tick();
      chk("hold_a_q", 32'(a_q), 32'hA5);
      set_a(1'b1, 1'b0, AW'('h123), 8'h00);
      repeat (RD_LAT) tick();
      chk("hold_mem", 32'(a_q), 32'hA5);
      // out of range
      set_a(1'b1, 1'b1, AW'(3072), 8'h33);
      tick();
      set_a(1'b1, 1'b0, AW'(3072), 8'h00);
      repeat (RD_LAT) tick();
      chk("oor_a", 32'(a_q), 32'h00);
      rd_b(AW'(3072), 8'h00, "oor_b");
      rd_b(AW'(0), 8'h00, "oor_alias_0");
      // random traffic in IDLE
      for (int i = 0; i < 3000; i++) begin
         rnd_in(1'b0);
         tick();
      end
      // requested clear, reset mid-sweep, restart from 0
      set_a(1'b0, 1'b0, '0, 8'h00);
      set_b(1'b0, '0);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      n = 0;
      while (busy && n < 100) begin
         rnd_in(1'b1);
         tick();
         n++;
      end
      clr_req = 1'b0;
      chk("mid_sweep_busy", 32'(busy), 32'd1);
      set_a(1'b0, 1'b0, '0, 8'h00);
      set_b(1'b0, '0);
      do_reset(3);
      sweep(1'b1, "restart_sweep_len");
      set_a(1'b0, 1'b0, '0, 8'h00);
      for (int i = 0; i < DEPTH; i++) begin
         set_b(1'b1, AW'(i));
         tick();
      end
      rd_b(AW'('h123), 8'h00, "clr_b_123");
      set_b(1'b0, '0);
      // read-first instance, no clear on reset
      a1_clken = 1'b1; a1_wren = 1'b1; a1_address = 4'd3; a1_data = 8'h5A;
      edge1();
      a1_data = 8'hA5;
      edge1();
      a1_wren = 1'b0;
      repeat (RD_LAT - 1) edge1();
      chk("rf_old", 32'(a1_q), 32'h5A);
      repeat (RD_LAT) edge1();
      chk("rf_new", 32'(a1_q), 32'hA5);
      a1_clken = 1'b0; a1_wren = 1'b1; a1_data = 8'hFF;
      repeat (2) edge1();
      chk("rf_hold", 32'(a1_q), 32'hA5);
      a1_clken = 1'b1; a1_wren = 1'b0;
      repeat (RD_LAT) edge1();
      chk("rf_hold_mem", 32'(a1_q), 32'hA5);
      a1_address = 4'd13; a1_wren = 1'b1; a1_data = 8'h33;
      edge1();
      a1_wren = 1'b0;
      repeat (RD_LAT) edge1();
      chk("rf_oor_a", 32'(a1_q), 32'h00);
      b1_clken = 1'b1; b1_address = 4'd13;
      repeat (RD_LAT) edge1();
      chk("rf_oor_b", 32'(b1_q), 32'h00);
      a1_address = 4'd3;
      clr1_req = 1'b1;
      edge1();
      clr1_req = 1'b0;
      n = 0;
      while (busy1 && n < 40) begin
         clr1_req = (n == 5);
         edge1();
         n++;
         if (n == 4) chk("rf_clr_a_q", 32'(a1_q), 32'h00);
      end
      clr1_req = 1'b0;
      chk("rf_clr_len", 32'(n), 32'(DEPTH1));
      b1_address = 4'd3;
      repeat (RD_LAT) edge1();
      chk("rf_clr_b", 32'(b1_q), 32'h3C);
      chk("rf_clr_a", 32'(a1_q), 32'h3C);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ram_dp_clr.md
Name: ram_dp_clr

Overview:
Parametrised dual-port block RAM with a hardware clear sequencer, successor to the single-port clock-enabled RAMs used across the arcade cores. Port A is read/write for the CPU side; port B is read-only for video/sprite fetch. A built-in engine fills every word with a constant after reset or on request, replacing the software clear loops.

Parameters:
ADDR_W, 11, address width of both ports.
DATA_W, 8, word width.
DEPTH, 2**ADDR_W, number of implemented words; may be non-power-of-two, e.g. 3072 with ADDR_W=12.
WRITE_FIRST, 1, port A read-during-write: 1 returns new data on a_q, 0 returns old data.
CLR_VALUE, 0, DATA_W-bit fill word.
CLEAR_ON_RESET, 1, 1 runs a clear automatically when reset_n deasserts.

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
a_clken  in  1  port A clock enable
a_address  in  ADDR_W  port A address
a_data  in  DATA_W  port A write data
a_wren  in  1  port A write enable, qualified by a_clken
a_q  out  DATA_W  port A registered read data
b_clken  in  1  port B clock enable
b_address  in  ADDR_W  port B address
b_q  out  DATA_W  port B registered read data
clr_req  in  1  single-cycle pulse, start a clear
busy  out  1  clear in progress

Behaviour:
- Clock and reset are fixed: one clock, `clock`; reset `reset_n` is asynchronous and active-low.
- Reset values:
  - a_q = 0, b_q = 0.
  - Clear counter = 0.
  - State = CLEAR and busy = 1 if CLEAR_ON_RESET, otherwise IDLE and busy = 0.
  - Array contents are not reset.
- FSM has two states, IDLE and CLEAR.
  - IDLE → CLEAR on clr_req=1; counter loads 0.
  - In CLEAR, each cycle writes CLR_VALUE to ram[counter] and increments the counter.
  - After writing DEPTH-1: → IDLE, busy = 0 on the next cycle.
  - A clear lasts exactly DEPTH cycles with busy = 1.
  - clr_req during CLEAR is ignored; it does not restart the sweep.
- Reset asserted mid-clear aborts the sweep. On release, the sweep restarts from 0 if CLEAR_ON_RESET, else the state is IDLE with partial contents.
- Port A, IDLE, a_clken=1:
  - a_wren=1: ram[a_address] <= a_data; a_q <= a_data if WRITE_FIRST, else old ram[a_address].
  - a_wren=0: a_q <= ram[a_address].
  - Latency is 1 cycle.
- Port A, a_clken=0: no write, a_q holds.
- Port A during CLEAR: writes are dropped. When a_clken=1, a_q <= 0; a_q holds otherwise.
- Port B, b_clken=1:
  - IDLE: b_q <= ram[b_address], latency 1.
  - CLEAR: b_q <= 0.
  - b_clken=0: b_q holds.
- Collision: port A writes and port B reads the same address in the same cycle. b_q returns the old word (read-first), deterministically in simulation.
- Out of range (address >= DEPTH): writes are ignored; reads return 0 on that port. No aliasing or wrap.
- Counter is ADDR_W+1 bits wide so DEPTH = 2**ADDR_W terminates without overflow.

Optional Feature:
Macro RAM_DP_OUTREG_EN.
- Defined: an extra output register stage on both a_q and b_q, for timing closure.
  - Read latency becomes 2 cycles.
  - The stage advances under the same port's clken.
  - It resets to 0 and is forced to 0 while busy, like the first stage.
- Undefined: latency is 1 and there is no extra flops.

Decomposition:
- Shared package ram_pkg:
  - state enum: ST_IDLE, ST_CLEAR.
  - function computing in-range from an address and DEPTH.
  - Latency constant RD_LAT: 1, or 2 when RAM_DP_OUTREG_EN is defined.
- One natural sub-module, ram_clr_seq: FSM plus counter. Outputs busy, clear write strobe and clear address. The array and port logic stay in ram_dp_clr.

Test Plan:
- Reset release with CLEAR_ON_RESET=1, DEPTH=3072, ADDR_W=12 → busy high exactly 3072 cycles; then b_q reads 0x00 at addresses 0, 1535 and 3071.
- Port A writes 0xA5 to 0x123 with WRITE_FIRST=1 → a_q=0xA5 next cycle. Repeat with WRITE_FIRST=0 over old 0x5A → a_q=0x5A, then a read returns 0xA5.
- Same-cycle A write 0x77 and B read at 0x040 (old 0x11) → b_q=0x11; next B read gives 0x77.
- a_clken=0 with a_wren=1, data 0xFF → memory unchanged, a_q holds its prior value.
- clr_req while IDLE after filling the RAM, then reset_n pulsed low at sweep cycle 100 → busy restarts, full DEPTH cycles from 0, all words 0x00. A mid-sweep clr_req has no effect.
- Address 3072 with DEPTH=3072: write 0x33 is ignored and the read returns 0; address 0 is unchanged. With RAM_DP_OUTREG_EN, a read of 0x123 returns 0xA5 2 cycles after issue.
